// File: rtl/fp_div_pkg.sv
// Shared types and constant builders for the iterative IEEE-754 divider.
package fp_div_pkg;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  typedef enum logic [2:0] {
    IDLE, CLASSIFY, SPECIAL, DIVIDE, NORM_ROUND, DONE
  } state_t;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Builders return a 64-bit word; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] fp_inf(input logic s, input int exp_w, input int man_w);
    return (64'(s) << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
  endfunction

  function automatic logic [63:0] fp_zero(input logic s, input int exp_w, input int man_w);
    return 64'(s) << (exp_w + man_w);
  endfunction

endpackage

// File: rtl/fp_div_iter_classify.sv
// Operand classifier: sorts a sign-less exponent/mantissa field into ZERO/NORMAL/INF/NAN.
module fp_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] in,
  output fp_class_t              cls,
  output logic                   is_snan
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = in[EXP_W+MAN_W-1:MAN_W];
  assign man_f = in[MAN_W-1:0];

  // Subnormals land in ZERO: the divider flushes them.
  always_comb begin
    cls = NORMAL;
    if (exp_f == '1) cls = (man_f != '0) ? NAN : INF;
    else if (exp_f == '0) cls = ZERO;
  end

  assign is_snan = (cls == NAN) && !man_f[MAN_W-1];

endmodule

// File: rtl/fp_div_iter.sv
// Sequential IEEE-754 divider: special-operand bypass, radix-2 restoring divide, RNE rounding.
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [4:0]             flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int Q_W   = MAN_W + 3;
  localparam int CNT_W = $clog2(Q_W + 1);
  localparam int EW2   = EXP_W + 2;
  localparam int BIAS  = fp_bias(EXP_W);

  localparam logic [63:0]  QNAN64   = fp_qnan(EXP_W, MAN_W);
  localparam logic [63:0]  INF64    = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [63:0]  ZERO64   = fp_zero(1'b0, EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN     = QNAN64[W-1:0];
  localparam logic [W-2:0] INF_MAG  = INF64[W-2:0];
  localparam logic [W-2:0] ZERO_MAG = ZERO64[W-2:0];
  localparam logic signed [EW2-1:0] E_MAX = EW2'((1 << EXP_W) - 1);

  state_t state, state_nx;

  logic [W-1:0]            a_q, b_q, out_q;
  logic [4:0]              flags_q;
  logic [MAN_W+1:0]        rem;
  logic [Q_W-1:0]          quo;
  logic [CNT_W-1:0]        cnt;
  logic signed [EW2-1:0]   exp_q;

  fp_class_t cls_a, cls_b;
  logic      snan_a, snan_b, sign_s, both_normal;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .in(a_q[W-2:0]), .cls(cls_a), .is_snan(snan_a)
  );
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .in(b_q[W-2:0]), .cls(cls_b), .is_snan(snan_b)
  );

  assign sign_s      = a_q[W-1] ^ b_q[W-1];
  assign both_normal = (cls_a == NORMAL) && (cls_b == NORMAL);

  // Restoring divide step
  logic [MAN_W+1:0] div_ext, rem_sel, rem_nx;
  logic             rem_ge;

  assign div_ext = {1'b0, 1'b1, b_q[MAN_W-1:0]};
  assign rem_ge  = rem >= div_ext;
  assign rem_sel = rem_ge ? (rem - div_ext) : rem;
  assign rem_nx  = rem_sel << 1;

  // Special-operand result
  logic [W-1:0] spec_out;
  logic [4:0]   spec_flags;

  always_comb begin
    spec_out   = {sign_s, ZERO_MAG};
    spec_flags = '0;
    if (cls_a == NAN || cls_b == NAN) begin
      spec_out           = QNAN;
      spec_flags[FLG_NV] = snan_a | snan_b;
    end else if ((cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
      spec_out           = QNAN;
      spec_flags[FLG_NV] = 1'b1;
    end else if (cls_a == INF) begin
      spec_out = {sign_s, INF_MAG};
    end else if (cls_b == ZERO) begin
      spec_out           = {sign_s, INF_MAG};
      spec_flags[FLG_DZ] = 1'b1;
    end
  end

  // Normalise and round; q_lo drops the (always-one) leading bit after normalisation.
  logic [MAN_W+1:0]      q_lo;
  logic signed [EW2-1:0] e_n, e_fin;
  logic                  guard, sticky, round_up, inexact;
  logic [MAN_W:0]        frac_sum;
  logic [W-1:0]          rnd_out;
  logic [4:0]            rnd_flags;

  always_comb begin
    if (quo[Q_W-1]) begin
      q_lo = quo[Q_W-2:0];
      e_n  = exp_q;
    end else begin
      q_lo = {quo[Q_W-3:0], 1'b0};
      e_n  = exp_q - EW2'(1);
    end
    guard    = q_lo[1];
    sticky   = q_lo[0] | (rem != '0);
    round_up = guard & (sticky | q_lo[2]);
    inexact  = guard | sticky;
    frac_sum = {1'b0, q_lo[MAN_W+1:2]} + (MAN_W+1)'(round_up);
    e_fin    = frac_sum[MAN_W] ? e_n + EW2'(1) : e_n;

    rnd_out            = {sign_s, e_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    rnd_flags          = '0;
    rnd_flags[FLG_NX]  = inexact;
    if (!e_fin[EW2-1] && e_fin >= E_MAX) begin
      rnd_out           = {sign_s, INF_MAG};
      rnd_flags[FLG_OF] = 1'b1;
      rnd_flags[FLG_NX] = 1'b1;
    end else if (e_fin[EW2-1] || e_fin == '0) begin
      rnd_out           = {sign_s, ZERO_MAG};
      rnd_flags[FLG_UF] = 1'b1;
      rnd_flags[FLG_NX] = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       if (in_valid) state_nx = CLASSIFY;
      CLASSIFY:   state_nx = both_normal ? DIVIDE : SPECIAL;
      SPECIAL:    state_nx = DONE;
      DIVIDE:     if (cnt == CNT_W'(1)) state_nx = NORM_ROUND;
      NORM_ROUND: state_nx = DONE;
      DONE:       if (out_ready) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  assign out   = out_q;
  assign flags = flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      flags_q <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      exp_q   <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
        end
        CLASSIFY: if (both_normal) begin
          rem   <= {1'b0, 1'b1, a_q[MAN_W-1:0]};
          quo   <= '0;
          cnt   <= CNT_W'(Q_W);
          exp_q <= EW2'({2'b00, a_q[W-2:MAN_W]}) - EW2'({2'b00, b_q[W-2:MAN_W]}) + EW2'(BIAS);
        end
        DIVIDE: begin
          rem <= rem_nx;
          quo <= {quo[Q_W-2:0], rem_ge};
          cnt <= cnt - CNT_W'(1);
        end
        SPECIAL: begin
          out_q   <= spec_out;
          flags_q <= spec_flags;
        end
        NORM_ROUND: begin
          out_q   <= rnd_out;
          flags_q <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: directed table, corner sequences, random vs reference model.
module tb_fp_div_iter;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a_i, b_i, out_o;
  logic [4:0]  flags_o;

  int checks = 0;
  int errors = 0;

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready),
    .out(out_o), .flags(flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [4:0]  f;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer quotient + remainder, then IEEE RNE and flush rules.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [4:0] f, output int lat);
    logic s;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    bit xn, xi, xz, yn, yi, yz;
    longint unsigned mx, my, num, m, rm;
    int e;
    s = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23];
    fx = x[22:0];  fy = y[22:0];
    xn = (ex == 8'hFF) && (fx != 0); xi = (ex == 8'hFF) && (fx == 0); xz = (ex == 0);
    yn = (ey == 8'hFF) && (fy != 0); yi = (ey == 8'hFF) && (fy == 0); yz = (ey == 0);
    f = 5'b0;
    lat = 2;
    r = {s, 31'h0};
    if (xn || yn) begin
      r = 32'h7FC00000;
      f[4] = (xn && !fx[22]) || (yn && !fy[22]);
    end else if ((xz && yz) || (xi && yi)) begin
      r = 32'h7FC00000;
      f[4] = 1'b1;
    end else if (xi) begin
      r = {s, 8'hFF, 23'h0};
    end else if (yz) begin
      r = {s, 8'hFF, 23'h0};
      f[3] = 1'b1;
    end else if (xz || yi) begin
      r = {s, 31'h0};
    end else begin
      lat = 28;
      mx = {40'd0, 1'b1, fx};
      my = {40'd0, 1'b1, fy};
      e = int'(ex) - int'(ey) + 127;
      if (mx >= my) num = mx << 23;
      else begin
        num = mx << 24;
        e = e - 1;
      end
      m  = num / my;
      rm = num % my;
      if ((2 * rm > my) || ((2 * rm == my) && m[0])) m = m + 1;
      if (m == (64'd1 << 24)) begin
        m = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 5'b00101;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 5'b00011;
      end else begin
        r = {s, e[7:0], m[22:0]};
        f[0] = (rm != 0);
      end
    end
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] v;
    int sel;
    v   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel == 0) begin
      case ($urandom_range(0, 4))
        0: v[30:0] = 31'h0;
        1: v[30:0] = 31'h7F800000;
        2: v[30:0] = 31'h7FC00000 | ($urandom & 32'h003FFFFF);
        3: v[30:0] = 31'h7F800001 | ($urandom & 32'h003FFFFF);
        default: v[30:23] = 8'h00;
      endcase
    end else if (sel <= 2) begin
      v[30:23] = 8'($urandom_range(1, 254));
    end else begin
      v[30:23] = 8'($urandom_range(100, 154));
    end
    return v;
  endfunction

  // Starts just after a posedge with the DUT idle; returns result, flags and accept-to-valid latency.
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input int hold,
                       output logic [31:0] r, output logic [4:0] f, output int cyc);
    a_i = oa; b_i = ob; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a_i = $urandom; b_i = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    r = out_o; f = flags_o;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; a_i = $urandom; b_i = $urandom;
      @(posedge clk); #1;
      chk("bp_out_stable", out_o, r);
      chk("bp_flags_stable", 32'(flags_o), 32'(f));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    if (hold > 0) begin
      chk("hs_out_valid_low", 32'(out_valid), 32'd0);
      chk("hs_in_ready_high", 32'(in_ready), 32'd1);
      chk("hs_out_retained", out_o, r);
    end
  endtask

  vec_t vecs[14];
  logic [31:0] r, er;
  logic [4:0]  f, ef;
  int cyc, elat;

  initial begin
    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28};
    vecs[3]  = '{32'h3F800000, 32'h80000000, 32'hFF800000, 5'b01000, 2};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2};
    vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2};
    vecs[6]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 2};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 5'b00000, 2};
    vecs[8]  = '{32'h3F800000, 32'h7F800000, 32'h00000000, 5'b00000, 2};
    vecs[9]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 28};
    vecs[10] = '{32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28};
    vecs[11] = '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 2};
    vecs[12] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 2};
    vecs[13] = '{32'hC0000000, 32'h3F000000, 32'hC0800000, 5'b00000, 28};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_i = '0; b_i = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", out_o, 32'h0);
    chk("rst_flags", 32'(flags_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, 0, r, f, cyc);
      chk($sformatf("vec%0d_out", i), r, vecs[i].r);
      chk($sformatf("vec%0d_flags", i), 32'(f), 32'(vecs[i].f));
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
    end

    // Backpressure: result held for 10 cycles while stray in_valid pulses arrive.
    do_op(32'h3F800000, 32'h40400000, 10, r, f, cyc);
    chk("bp_result", r, 32'h3EAAAAAB);
    chk("bp_result_flags", 32'(f), 32'd1);

    // Asynchronous reset in the middle of DIVIDE.
    a_i = 32'h40C00000; b_i = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_flags", 32'(flags_o), 32'd0);
    chk("midrst_out", out_o, 32'h0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h40C00000, 32'h40000000, 0, r, f, cyc);
    chk("postrst_out", r, 32'h40400000);
    chk("postrst_flags", 32'(f), 32'd0);
    chk("postrst_latency", 32'(cyc), 32'd28);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ra, rb;
      ra = gen_operand();
      rb = gen_operand();
      ref_div(ra, rb, er, ef, elat);
      do_op(ra, rb, 0, r, f, cyc);
      chk($sformatf("rnd%0d_out(%h/%h)", n, ra, rb), r, er);
      chk($sformatf("rnd%0d_flags(%h/%h)", n, ra, rb), 32'(f), 32'(ef));
      chk($sformatf("rnd%0d_latency", n), 32'(cyc), 32'(elat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
Parametrised, sequential IEEE-754 divider and the successor to the combinational division special-case classifier. It handles special operands with a short bypass path. Normal operands go through a radix-2 restoring mantissa divide, round-to-nearest-even and exception flags. Valid/ready handshakes on both sides let it sit in the FPU datapath next to the add/mul units.

Parameters:
EXP_W, 8, exponent field width.
MAN_W, 23, stored mantissa width; total word width W = 1+EXP_W+MAN_W.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operands a, b valid.
in_ready  out  1  block can accept operands.
a  in  W  dividend.
b  in  W  divisor.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out  out  W  quotient.
flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.

Behaviour:
- Clocking and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, flags=0, all datapath registers 0.
- Accept: transfer when in_valid & in_ready. in_ready is 1 only in IDLE. Operands are registered on accept.
- Classification: exp all-ones and man≠0 -> NAN. Exp all-ones and man=0 -> INF. Exp=0 -> ZERO (subnormal inputs flushed to zero). Otherwise NORMAL.
- FSM states: IDLE -> CLASSIFY -> {SPECIAL | DIVIDE} -> NORM_ROUND -> DONE -> IDLE.
  - SPECIAL goes straight to DONE.
- Special results (sign s = a[W-1]^b[W-1]). Canonical qNaN = sign 0, exp all-ones, man MSB 1, rest 0 (0x7FC00000 at defaults).
  - Any NaN operand -> qNaN. invalid=1 if that NaN has man MSB=0 (sNaN).
  - 0/0 or Inf/Inf -> qNaN, invalid=1.
  - NORMAL/ZERO -> {s, Inf}, div_by_zero=1.
  - Inf/NORMAL or Inf/ZERO -> {s, Inf}.
  - ZERO/NORMAL, ZERO/Inf, NORMAL/Inf -> {s, 0}.
- Special latency: out_valid rises 2 cycles after the accept edge.
- Normal path:
  - Significands with hidden 1, MAN_W+1 bits each.
  - DIVIDE runs Q_W = MAN_W+3 iterations, one quotient bit per cycle, using a counter of width clog2(Q_W+1).
  - Biased exponent computed in EXP_W+2-bit signed arithmetic: e = ea - eb + BIAS, where BIAS = 2^(EXP_W-1)-1.
- NORM_ROUND, in this order:
  1. If quotient MSB=0: shift left 1 and e -= 1.
  2. Guard = next bit after the MAN_W+1 kept bits; sticky = OR of remaining bits OR (remainder≠0).
  3. Round to nearest even. A mantissa carry-out renormalises and sets e += 1.
  4. inexact = guard|sticky.
  5. e ≥ 2^EXP_W-1 -> {s, Inf}, overflow=1, inexact=1.
  6. e ≤ 0 -> {s, 0}, underflow=1, inexact=1 (flush to zero).
- Normal latency: out_valid rises MAN_W+5 cycles after accept (28 at defaults).
- DONE:
  - out_valid=1; out and flags held stable while out_ready=0.
  - When out_valid & out_ready: next state IDLE, out_valid=0, in_ready=1 on the following cycle. No back-to-back accept in the same cycle.
  - out and flags retain their last value after the handshake.
- Input changes while not IDLE are ignored.
- Reset asserted mid-operation aborts immediately and returns all outputs to their reset values.

Decomposition:
- Package fp_div_pkg holds:
  - class enum {ZERO, NORMAL, INF, NAN}.
  - FSM state enum.
  - Functions built from EXP_W/MAN_W: bias, canonical qNaN, signed Inf, signed zero.
  - Flag bit index constants.
- One sub-module, fp_classify (combinational, parametrised EXP_W/MAN_W): in -> class, is_snan. Instantiated twice.

Test Plan:
1. Exact divide: a=0x40C00000, b=0x40000000 (6/2) -> out=0x40400000, flags=0, out_valid exactly 28 cycles after accept.
2. Rounding: 0x3F800000/0x40400000 (1/3) -> 0x3EAAAAAB, flags=00001. Also 0x3F800000/0x3F800000 -> 0x3F800000, flags=0.
3. Specials, each with out_valid 2 cycles after accept:
   - 0x3F800000/0x80000000 -> 0xFF800000, div_by_zero.
   - 0/0 -> 0x7FC00000, invalid.
   - 0x7F800000/0x7F800000 -> 0x7FC00000, invalid.
   - 0x7F800001/0x3F800000 -> 0x7FC00000, invalid.
   - 0x7FC00000/0x3F800000 -> 0x7FC00000, flags=0.
   - 0x3F800000/0x7F800000 -> 0x00000000.
4. Range exceptions:
   - 0x7F000000/0x3E800000 -> 0x7F800000, flags=00101.
   - 0x00800000/0x40000000 -> 0x00000000, flags=00011.
   - Subnormal a=0x00000001 / 1.0 -> 0x00000000, flags=0.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out/flags stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> one transfer, in_ready=1 the next cycle.
6. Reset mid-op: assert rst_n=0 asynchronously (off clock edge) at DIVIDE iteration 10 -> out_valid=0, in_ready=1, flags=0 immediately. After release, a fresh 6/2 gives 0x40400000.
